zx_dram_arbiter: RTL and testbench

- Time-multiplexed DRAM access controller for the Pentagon memory path.
- Shares one multiplexed-address DRAM bank between three requesters: video fetch, CBR refresh, and CPU.
- Drives the CPU/video address-mux select, RAS/CAS/WE, and the row/column address.
- Emits the latch strobe for the video data register, and acks for CPU and refresh.

---
 rtl/zx_dram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_zx_dram_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/zx_dram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// zx_dram_arbiter - Pentagon DRAM slot arbiter for video, CBR refresh and CPU. Rev 1.0
// ----------------------------------------------------------------------------
module zx_dram_arbiter #(
  parameter int MA_W         = 8,
  parameter int CPU_MAX_SKIP = 6,
  parameter int SKIP_W       = 3
) (
  input  logic              C,
  input  logic              R,
  input  logic              vid_req,
  input  logic [2*MA_W-1:0] vid_addr,
  input  logic              ref_req,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2*MA_W-1:0] cpu_addr,
  output logic [MA_W-1:0]   ma,
  output logic              ras_n,
  output logic              cas_n,
  output logic              we_n,
  output logic              mux_sel,
  output logic              vid_latch,
  output logic              cpu_ack,
  output logic              ref_ack,
  output logic              cpu_wait
);

  typedef enum logic [2:0] {
    S_IDLE, S_RAS, S_CAS, S_DATA, S_PRE, S_REF1, S_REF2, S_REF3
  } state_t;

  typedef enum logic [1:0] {K_NONE, K_VID, K_REF, K_CPU} kind_t;

  localparam logic [SKIP_W-1:0] C_SKIP_MAX = SKIP_W'(CPU_MAX_SKIP);

  state_t              state_q, state_d;
  kind_t               kind_q, kind_d;
  logic [2*MA_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [SKIP_W-1:0]   skip_q, skip_d;
  logic [MA_W-1:0]     ma_q, ma_d;
  logic                ras_n_q, ras_n_d, cas_n_q, cas_n_d, we_n_q, we_n_d;
  logic                mux_sel_q, mux_sel_d;
  logic                vid_latch_q, vid_latch_d, cpu_ack_q, cpu_ack_d, ref_ack_q, ref_ack_d;
  logic                w_decide, w_force_cpu;
  logic [SKIP_W-1:0]   w_skip_inc, w_skip_next;

  // Outputs are registered from the current state, so pins lag the state by one clock.
  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    addr_d      = addr_q;
    we_d        = we_q;
    skip_d      = skip_q;
    ma_d        = ma_q;
    ras_n_d     = 1'b1;
    cas_n_d     = 1'b1;
    we_n_d      = 1'b1;
    mux_sel_d   = mux_sel_q;
    vid_latch_d = 1'b0;
    cpu_ack_d   = 1'b0;
    ref_ack_d   = 1'b0;
    w_decide    = (state_q == S_IDLE) || (state_q == S_PRE);
    w_force_cpu = cpu_req && (skip_q == C_SKIP_MAX);
    w_skip_inc  = (skip_q == C_SKIP_MAX) ? skip_q : skip_q + SKIP_W'(1);
    w_skip_next = cpu_req ? w_skip_inc : '0;

    case (state_q)
      S_RAS: begin
        ras_n_d = 1'b0;
        ma_d    = addr_q[2*MA_W-1:MA_W];
        state_d = S_CAS;
      end
      S_CAS: begin
        ras_n_d = 1'b0;
        cas_n_d = 1'b0;
        ma_d    = addr_q[MA_W-1:0];
        we_n_d  = ~((kind_q == K_CPU) && we_q);
        state_d = S_DATA;
      end
      S_DATA: begin
        ras_n_d     = 1'b0;
        cas_n_d     = 1'b0;
        we_n_d      = we_n_q;
        vid_latch_d = (kind_q == K_VID);
        cpu_ack_d   = (kind_q == K_CPU);
        state_d     = S_PRE;
      end
      S_REF1: begin
        cas_n_d = 1'b0;
        ma_d    = '0;
        state_d = S_REF2;
      end
      S_REF2: begin
        ras_n_d = 1'b0;
        cas_n_d = 1'b0;
        ma_d    = '0;
        state_d = S_REF3;
      end
      S_REF3: begin
        ras_n_d   = 1'b0;
        ma_d      = '0;
        ref_ack_d = 1'b1;
        state_d   = S_PRE;
      end
      default: ;
    endcase

    // Back-to-back arbitration: IDLE and PRE are the only decision points.
    if (w_decide) begin
      state_d = S_IDLE;
      kind_d  = K_NONE;
      skip_d  = '0;
      if (w_force_cpu || (cpu_req && !vid_req && !ref_req)) begin
        state_d   = S_RAS;
        kind_d    = K_CPU;
        addr_d    = cpu_addr;
        we_d      = cpu_we;
        mux_sel_d = 1'b0;
      end else if (vid_req) begin
        state_d   = S_RAS;
        kind_d    = K_VID;
        addr_d    = vid_addr;
        we_d      = 1'b0;
        mux_sel_d = 1'b1;
        skip_d    = w_skip_next;
      end else if (ref_req) begin
        state_d = S_REF1;
        kind_d  = K_REF;
        skip_d  = w_skip_next;
      end
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q     <= S_IDLE;
      kind_q      <= K_NONE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      skip_q      <= '0;
      ma_q        <= '0;
      ras_n_q     <= 1'b1;
      cas_n_q     <= 1'b1;
      we_n_q      <= 1'b1;
      mux_sel_q   <= 1'b0;
      vid_latch_q <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ref_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      skip_q      <= skip_d;
      ma_q        <= ma_d;
      ras_n_q     <= ras_n_d;
      cas_n_q     <= cas_n_d;
      we_n_q      <= we_n_d;
      mux_sel_q   <= mux_sel_d;
      vid_latch_q <= vid_latch_d;
      cpu_ack_q   <= cpu_ack_d;
      ref_ack_q   <= ref_ack_d;
    end
  end

  assign ma        = ma_q;
  assign ras_n     = ras_n_q;
  assign cas_n     = cas_n_q;
  assign we_n      = we_n_q;
  assign mux_sel   = mux_sel_q;
  assign vid_latch = vid_latch_q;
  assign cpu_ack   = cpu_ack_q;
  assign ref_ack   = ref_ack_q;
  assign cpu_wait  = cpu_req && !((kind_q == K_CPU) && (state_q != S_IDLE));

endmodule
`default_nettype wire

// File: tb/tb_zx_dram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_zx_dram_arbiter - directed self-checking bench for zx_dram_arbiter. Rev 1.0
// ----------------------------------------------------------------------------
module tb_zx_dram_arbiter;

  logic        C = 1'b0;
  logic        R = 1'b1;
  logic        vid_req = 1'b0, ref_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] vid_addr = '0, cpu_addr = '0;
  logic [7:0]  ma;
  logic        ras_n, cas_n, we_n, mux_sel, vid_latch, cpu_ack, ref_ack, cpu_wait;

  int checks = 0;
  int errors = 0;

  zx_dram_arbiter #(.MA_W(8), .CPU_MAX_SKIP(6), .SKIP_W(3)) dut (
    .C(C), .R(R),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .ref_req(ref_req),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .ma(ma), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .mux_sel(mux_sel),
    .vid_latch(vid_latch), .cpu_ack(cpu_ack), .ref_ack(ref_ack), .cpu_wait(cpu_wait)
  );

  always #5 C = ~C;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed pin view: {ras_n, cas_n, we_n, mux_sel, vid_latch, cpu_ack, ref_ack, ma}
  task automatic pins(input string tag, input logic r, input logic c, input logic w,
                      input logic m, input logic vl, input logic ca, input logic ra,
                      input logic [7:0] a);
    check(tag, {17'd0, ras_n, cas_n, we_n, mux_sel, vid_latch, cpu_ack, ref_ack, ma},
               {17'd0, r, c, w, m, vl, ca, ra, a});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge C);
  endtask

  int t_v, t_r, t_c, nv, nv_first, ack1, ack2, nack;

  initial begin
    step(3);
    pins("reset", 1, 1, 1, 0, 0, 0, 0, 8'h00);
    R = 1'b0;
    step(1);

    // CPU read 0x12AB
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h12AB;
    #1 check("rd_wait_hi", cpu_wait, 1);
    step(1);
    pins("rd_idle", 1, 1, 1, 0, 0, 0, 0, 8'h00);
    step(1);
    pins("rd_ras", 0, 1, 1, 0, 0, 0, 0, 8'h12);
    check("rd_wait_lo", cpu_wait, 0);
    step(1);
    pins("rd_cas", 0, 0, 1, 0, 0, 0, 0, 8'hAB);
    step(1);
    pins("rd_data", 0, 0, 1, 0, 0, 1, 0, 8'hAB);
    cpu_req = 0;
    step(1);
    pins("rd_pre", 1, 1, 1, 0, 0, 0, 0, 8'hAB);
    step(1);

    // CPU write 0x3401
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h3401;
    step(1);
    pins("wr_idle", 1, 1, 1, 0, 0, 0, 0, 8'hAB);
    step(1);
    pins("wr_ras", 0, 1, 1, 0, 0, 0, 0, 8'h34);
    step(1);
    pins("wr_cas", 0, 0, 0, 0, 0, 0, 0, 8'h01);
    step(1);
    pins("wr_data", 0, 0, 0, 0, 0, 1, 0, 8'h01);
    cpu_req = 0; cpu_we = 0;
    step(1);
    pins("wr_pre", 1, 1, 1, 0, 0, 0, 0, 8'h01);
    step(1);

    // Video and CPU together: video first, CPU back-to-back
    vid_req = 1; vid_addr = 16'h5678; cpu_req = 1; cpu_addr = 16'h9ABC;
    step(1);
    pins("vc_grant", 1, 1, 1, 1, 0, 0, 0, 8'h01);
    step(1);
    pins("vc_vras", 0, 1, 1, 1, 0, 0, 0, 8'h56);
    step(1);
    pins("vc_vcas", 0, 0, 1, 1, 0, 0, 0, 8'h78);
    step(1);
    pins("vc_vdata", 0, 0, 1, 1, 1, 0, 0, 8'h78);
    vid_req = 0;
    step(1);
    pins("vc_pre", 1, 1, 1, 0, 0, 0, 0, 8'h78);
    step(1);
    pins("vc_cras", 0, 1, 1, 0, 0, 0, 0, 8'h9A);
    step(1);
    pins("vc_ccas", 0, 0, 1, 0, 0, 0, 0, 8'hBC);
    step(1);
    pins("vc_cdata", 0, 0, 1, 0, 0, 1, 0, 8'hBC);
    cpu_req = 0;
    step(2);

    // CBR refresh alone
    ref_req = 1;
    step(1);
    pins("rf_idle", 1, 1, 1, 0, 0, 0, 0, 8'hBC);
    step(1);
    pins("rf_ref1", 1, 0, 1, 0, 0, 0, 0, 8'h00);
    step(1);
    pins("rf_ref2", 0, 0, 1, 0, 0, 0, 0, 8'h00);
    step(1);
    pins("rf_ref3", 0, 1, 1, 0, 0, 0, 1, 8'h00);
    ref_req = 0;
    step(1);
    pins("rf_pre", 1, 1, 1, 0, 0, 0, 0, 8'h00);
    step(1);

    // All three at once: video, refresh, then CPU
    vid_req = 1; ref_req = 1; cpu_req = 1; vid_addr = 16'h0102; cpu_addr = 16'h0304;
    t_v = 0; t_r = 0; t_c = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (vid_latch) begin t_v = i; vid_req = 0; end
      if (ref_ack)   begin t_r = i; ref_req = 0; end
      if (cpu_ack)   begin t_c = i; cpu_req = 0; end
    end
    check("all3_vid_t", t_v, 4);
    check("all3_ref_t", t_r, 8);
    check("all3_cpu_t", t_c, 12);

    // Starvation bound with video held high
    vid_req = 1; cpu_req = 1; vid_addr = 16'h1111; cpu_addr = 16'h2222;
    nv = 0; nv_first = 0; ack1 = 0; ack2 = 0; nack = 0;
    for (int i = 1; i <= 64; i++) begin
      step(1);
      if (vid_latch) nv++;
      if (cpu_ack) begin
        nack++;
        if (ack1 == 0) begin ack1 = i; nv_first = nv; end
        else if (ack2 == 0) ack2 = i;
      end
      if (i == 28) cpu_req = 0;
      if (i == 29) cpu_req = 1;
      if (i == 60) begin cpu_req = 0; vid_req = 0; end
    end
    check("starve_vid_before_cpu", nv_first, 6);
    check("starve_ack1_t", ack1, 28);
    check("starve_ack2_t", ack2, 60);
    check("starve_vid_total", nv, 13);
    check("starve_ack_count", nack, 2);
    pins("starve_idle", 1, 1, 1, 0, 0, 0, 0, 8'h22);
    step(1);

    // Reset during CAS of a CPU write, request kept high
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h3401;
    step(2);
    pins("rst_ras", 0, 1, 1, 0, 0, 0, 0, 8'h34);
    step(1);
    pins("rst_cas", 0, 0, 0, 0, 0, 0, 0, 8'h01);
    R = 1;
    step(1);
    pins("rst_abort", 1, 1, 1, 0, 0, 0, 0, 8'h00);
    R = 0;
    #1 check("rst_wait", cpu_wait, 1);
    step(1);
    pins("rst_noack", 1, 1, 1, 0, 0, 0, 0, 8'h00);
    step(1);
    pins("rst_reras", 0, 1, 1, 0, 0, 0, 0, 8'h34);
    step(1);
    pins("rst_recas", 0, 0, 0, 0, 0, 0, 0, 8'h01);
    step(1);
    pins("rst_reack", 0, 0, 0, 0, 0, 1, 0, 8'h01);
    cpu_req = 0; cpu_we = 0;
    step(1);
    pins("rst_pre", 1, 1, 1, 0, 0, 0, 0, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
